// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, sizes and field helpers for the partial-sum MAC engine
package pe_pkg;

    localparam int LANES      = 3;
    localparam int DATA_W     = 16;
    localparam int ACC_W      = 32;
    localparam int COORD_W    = 7;
    localparam int PSUM_DEPTH = 128;
    localparam int PSUM_IDX_W = $clog2(PSUM_DEPTH);
    localparam int ADDR_W     = 3 * COORD_W;
    localparam int PROD_W     = 2 * DATA_W;
    localparam int LANE_CNT_W = $clog2(LANES + 1);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] k;
    } pe_addr_t;

    typedef struct packed {
        pe_addr_t           addr;
        logic [DATA_W-1:0]  w;
        logic [DATA_W-1:0]  ia;
    } lane_t;

    typedef enum logic {
        SIDE_RIGHT = 1'b0,
        SIDE_LEFT  = 1'b1
    } side_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Output channel folds onto the array: k mod PSUM_DEPTH.
    function automatic logic [PSUM_IDX_W-1:0] get_k(input pe_addr_t a);
        return PSUM_IDX_W'(a.k % PSUM_DEPTH);
    endfunction

endpackage

// File: rtl/pe_mac_accum_if.sv
// rtl/pe_mac_accum_if.sv - ping-pong buffer inputs, control and drain stream of the MAC engine
interface pe_mac_accum_if;
    import pe_pkg::*;

    logic                         i_right_ready;
    logic [LANES*ADDR_W-1:0]      i_addr_right;
    logic [LANES*DATA_W-1:0]      i_w_right;
    logic [LANES*DATA_W-1:0]      i_ia_right;
    logic                         i_left_ready;
    logic [LANES*ADDR_W-1:0]      i_addr_left;
    logic [LANES*DATA_W-1:0]      i_w_left;
    logic [LANES*DATA_W-1:0]      i_ia_left;
    logic                         o_right_taken;
    logic                         o_left_taken;
    logic                         o_busy;
    logic                         i_clear;
    logic                         i_drain;
    logic                         o_psum_valid;
    logic                         i_psum_ready;
    logic [PSUM_IDX_W-1:0]        o_psum_idx;
    logic [ACC_W-1:0]             o_psum_data;
    logic                         o_done;

    modport master (
        output i_right_ready, i_addr_right, i_w_right, i_ia_right,
        output i_left_ready, i_addr_left, i_w_left, i_ia_left,
        output i_clear, i_drain, i_psum_ready,
        input  o_right_taken, o_left_taken, o_busy,
        input  o_psum_valid, o_psum_idx, o_psum_data, o_done
    );

    modport slave (
        input  i_right_ready, i_addr_right, i_w_right, i_ia_right,
        input  i_left_ready, i_addr_left, i_w_left, i_ia_left,
        input  i_clear, i_drain, i_psum_ready,
        output o_right_taken, o_left_taken, o_busy,
        output o_psum_valid, o_psum_idx, o_psum_data, o_done
    );

endinterface

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed add clamped to the W-bit two's complement range
module sat_add #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    logic signed [W:0] sum;

    // A carry into the guard bit that disagrees with the sign bit means overflow.
    always_comb begin
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = sum[W-1:0];
        end
    end

endmodule

// File: rtl/pe_mac_accum.sv
// rtl/pe_mac_accum.sv - serialises ping-pong lane buffers into a saturating partial-sum array with read-and-clear drain
module pe_mac_accum
    import pe_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    pe_mac_accum_if.slave bus
);

    localparam logic [LANE_CNT_W-1:0] LANE_END = LANE_CNT_W'(LANES);
    localparam logic [PSUM_IDX_W-1:0] LAST_IDX = PSUM_IDX_W'(PSUM_DEPTH - 1);

    state_e                  state_q, state_d;
    side_e                   side_q, side_d;
    logic [LANE_CNT_W-1:0]   lane_cnt_q, lane_cnt_d;
    lane_t [LANES-1:0]       buf_q, buf_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic [PSUM_IDX_W-1:0]   prod_k_q, prod_k_d;
    logic                    prod_vld_q, prod_vld_d;
    logic [PSUM_IDX_W-1:0]   drain_idx_q, drain_idx_d;
    logic                    right_taken_q, right_taken_d;
    logic                    left_taken_q, left_taken_d;
    logic                    done_q, done_d;
    logic signed [ACC_W-1:0] psum_q [PSUM_DEPTH];
    logic signed [ACC_W-1:0] psum_d [PSUM_DEPTH];

    logic signed [ACC_W-1:0] acc_in;
    logic signed [ACC_W-1:0] acc_sum;
    lane_t                   cur_lane;
    logic                    side_ready;

    assign acc_in = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // Read and write of the target entry share a cycle, so back-to-back lanes on one k chain naturally.
    sat_add #(.W(ACC_W)) u_sat_add (
        .a (psum_q[prod_k_q]),
        .b (acc_in),
        .y (acc_sum)
    );

    always_comb begin
        cur_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_cnt_q == LANE_CNT_W'(i)) begin
                cur_lane = buf_q[i];
            end
        end
    end

    assign side_ready = (side_q == SIDE_RIGHT) ? bus.i_right_ready : bus.i_left_ready;

    always_comb begin
        state_d       = state_q;
        side_d        = side_q;
        lane_cnt_d    = lane_cnt_q;
        buf_d         = buf_q;
        prod_d        = prod_q;
        prod_k_d      = prod_k_q;
        prod_vld_d    = 1'b0;
        drain_idx_d   = drain_idx_q;
        right_taken_d = 1'b0;
        left_taken_d  = 1'b0;
        done_d        = 1'b0;
        psum_d        = psum_q;

        if (prod_vld_q) begin
            psum_d[prod_k_q] = acc_sum;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.i_clear) begin
                    psum_d = '{default: '0};
                end else if (side_ready) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (side_q == SIDE_RIGHT) begin
                            buf_d[i].addr = bus.i_addr_right[i*ADDR_W +: ADDR_W];
                            buf_d[i].w    = bus.i_w_right[i*DATA_W +: DATA_W];
                            buf_d[i].ia   = bus.i_ia_right[i*DATA_W +: DATA_W];
                        end else begin
                            buf_d[i].addr = bus.i_addr_left[i*ADDR_W +: ADDR_W];
                            buf_d[i].w    = bus.i_w_left[i*DATA_W +: DATA_W];
                            buf_d[i].ia   = bus.i_ia_left[i*DATA_W +: DATA_W];
                        end
                    end
                    right_taken_d = (side_q == SIDE_RIGHT);
                    left_taken_d  = (side_q == SIDE_LEFT);
                    side_d        = (side_q == SIDE_RIGHT) ? SIDE_LEFT : SIDE_RIGHT;
                    lane_cnt_d    = '0;
                    state_d       = S_MAC;
                end else if (bus.i_drain) begin
                    drain_idx_d = '0;
                    state_d     = S_DRAIN;
                end
            end

            S_MAC: begin
                // One product per cycle; the extra final cycle lets the last lane accumulate.
                if (lane_cnt_q != LANE_END) begin
                    prod_d     = $signed({{DATA_W{cur_lane.w[DATA_W-1]}}, cur_lane.w})
                               * $signed({{DATA_W{cur_lane.ia[DATA_W-1]}}, cur_lane.ia});
                    prod_k_d   = get_k(cur_lane.addr);
                    prod_vld_d = 1'b1;
                    lane_cnt_d = lane_cnt_q + 1'b1;
                end else begin
                    lane_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end

            S_DRAIN: begin
                if (bus.i_psum_ready) begin
                    psum_d[drain_idx_q] = '0;
                    if (drain_idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        drain_idx_d = drain_idx_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            side_q        <= SIDE_RIGHT;
            lane_cnt_q    <= '0;
            buf_q         <= '0;
            prod_q        <= '0;
            prod_k_q      <= '0;
            prod_vld_q    <= 1'b0;
            drain_idx_q   <= '0;
            right_taken_q <= 1'b0;
            left_taken_q  <= 1'b0;
            done_q        <= 1'b0;
            psum_q        <= '{default: '0};
        end else begin
            state_q       <= state_d;
            side_q        <= side_d;
            lane_cnt_q    <= lane_cnt_d;
            buf_q         <= buf_d;
            prod_q        <= prod_d;
            prod_k_q      <= prod_k_d;
            prod_vld_q    <= prod_vld_d;
            drain_idx_q   <= drain_idx_d;
            right_taken_q <= right_taken_d;
            left_taken_q  <= left_taken_d;
            done_q        <= done_d;
            psum_q        <= psum_d;
        end
    end

    assign bus.o_right_taken = right_taken_q;
    assign bus.o_left_taken  = left_taken_q;
    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_psum_valid  = (state_q == S_DRAIN);
    assign bus.o_psum_idx    = (state_q == S_DRAIN) ? drain_idx_q : '0;
    assign bus.o_psum_data   = (state_q == S_DRAIN) ? psum_q[drain_idx_q] : '0;
    assign bus.o_done        = done_q;

endmodule

// File: tb/tb_pe_mac_accum.sv
// tb/tb_pe_mac_accum.sv - scoreboard bench for the partial-sum MAC engine
module tb_pe_mac_accum;
    import pe_pkg::*;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pe_mac_accum_if bus();

    pe_mac_accum dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int     idx;
        longint data;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    longint model [PSUM_DEPTH];
    int     lw  [2][LANES];
    int     lia [2][LANES];
    int     lk  [2][LANES];
    bit     exp_side;
    exp_t   sb [$];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic set_lane(input int s, input int i, input int w, input int ia, input int k);
        lw[s][i]  = w;
        lia[s][i] = ia;
        lk[s][i]  = k;
    endtask

    task automatic load_side(input int s);
        logic [LANES*ADDR_W-1:0] a;
        logic [LANES*DATA_W-1:0] wv;
        logic [LANES*DATA_W-1:0] iv;
        for (int i = 0; i < LANES; i++) begin
            a[i*ADDR_W +: ADDR_W]  = {COORD_W'(i + 1), COORD_W'(3), COORD_W'(lk[s][i])};
            wv[i*DATA_W +: DATA_W] = DATA_W'(lw[s][i]);
            iv[i*DATA_W +: DATA_W] = DATA_W'(lia[s][i]);
        end
        if (s == 0) begin
            bus.i_addr_right = a;
            bus.i_w_right    = wv;
            bus.i_ia_right   = iv;
        end else begin
            bus.i_addr_left  = a;
            bus.i_w_left     = wv;
            bus.i_ia_left    = iv;
        end
    endtask

    task automatic apply_side(input int s);
        for (int i = 0; i < LANES; i++) begin
            model[lk[s][i] % PSUM_DEPTH] = sat(model[lk[s][i] % PSUM_DEPTH] + longint'(lw[s][i]) * longint'(lia[s][i]));
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},   bus.o_busy, 0);
        check({tag, "_rtaken"}, bus.o_right_taken, 0);
        check({tag, "_ltaken"}, bus.o_left_taken, 0);
        check({tag, "_valid"},  bus.o_psum_valid, 0);
        check({tag, "_idx"},    bus.o_psum_idx, 0);
        check({tag, "_data"},   bus.o_psum_data, 0);
        check({tag, "_done"},   bus.o_done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_right_ready = 1'b0;
        bus.i_left_ready  = 1'b0;
        bus.i_clear       = 1'b0;
        bus.i_drain       = 1'b0;
        bus.i_psum_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        exp_side = 1'b0;
        for (int j = 0; j < PSUM_DEPTH; j++) model[j] = 0;
    endtask

    // Starts and ends at a negedge with the engine idle.
    task automatic send_buf(input bit clr_mac);
        int s;
        s = exp_side ? 1 : 0;
        load_side(s);
        if (s == 0) bus.i_right_ready = 1'b1;
        else        bus.i_left_ready  = 1'b1;
        @(negedge clk);
        check("taken_r", bus.o_right_taken, (s == 0));
        check("taken_l", bus.o_left_taken, (s == 1));
        check("busy_first", bus.o_busy, 1);
        bus.i_right_ready = 1'b0;
        bus.i_left_ready  = 1'b0;
        bus.i_clear       = clr_mac;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("busy_mac", bus.o_busy, 1);
            check("taken_once", bus.o_right_taken | bus.o_left_taken, 0);
        end
        @(negedge clk);
        bus.i_clear = 1'b0;
        check("busy_end", bus.o_busy, 0);
        apply_side(s);
        exp_side = ~exp_side;
    endtask

    task automatic do_drain(input bit toggle);
        int pat [4] = '{1, 0, 0, 1};
        int accepted;
        int cyc;
        bit rdy;
        for (int j = 0; j < PSUM_DEPTH; j++) begin
            sb.push_back('{j, model[j]});
            model[j] = 0;
        end
        bus.i_drain = 1'b1;
        @(negedge clk);
        bus.i_drain = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < PSUM_DEPTH && cyc < 2000) begin
            rdy = toggle ? (pat[cyc % 4] != 0) : 1'b1;
            bus.i_psum_ready = rdy;
            if (bus.o_psum_valid && sb.size() > 0) begin
                check("drain_idx", bus.o_psum_idx, sb[0].idx);
                check("drain_data", $signed(bus.o_psum_data), sb[0].data);
                if (rdy) begin
                    void'(sb.pop_front());
                    accepted++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_count", accepted, PSUM_DEPTH);
        check("done_pulse", bus.o_done, 1);
        check("valid_fall", bus.o_psum_valid, 0);
        bus.i_psum_ready = 1'b0;
        @(negedge clk);
        check("done_once", bus.o_done, 0);
        check("idle_after_drain", bus.o_busy, 0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_addr_right = '0;
        bus.i_w_right    = '0;
        bus.i_ia_right   = '0;
        bus.i_addr_left  = '0;
        bus.i_w_left     = '0;
        bus.i_ia_left    = '0;
        do_reset();

        // Basic right buffer, same-k chaining and zero-padded lane.
        set_lane(0, 0, 3, 4, 5);
        set_lane(0, 1, -2, 7, 5);
        set_lane(0, 2, 0, 0, 0);
        send_buf(1'b0);
        do_drain(1'b0);

        // Left alone is ignored from reset; then both high alternate R, L, R.
        do_reset();
        set_lane(0, 0, 1, 1, 10);
        set_lane(0, 1, 2, 3, 11);
        set_lane(0, 2, -1, 5, 10);
        set_lane(1, 0, 4, 4, 10);
        set_lane(1, 1, 0, 0, 0);
        set_lane(1, 2, 7, -3, 127);
        load_side(0);
        load_side(1);
        bus.i_left_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("left_alone_taken", bus.o_left_taken, 0);
            check("left_alone_busy", bus.o_busy, 0);
        end
        bus.i_right_ready = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            check("alt_r", bus.o_right_taken, (n == 1 || n == 11));
            check("alt_l", bus.o_left_taken, (n == 6));
        end
        bus.i_right_ready = 1'b0;
        bus.i_left_ready  = 1'b0;
        apply_side(0);
        apply_side(1);
        apply_side(0);
        exp_side = 1'b1;
        do_drain(1'b0);

        // Saturation at both rails, then a stalled drain and an immediate second drain.
        do_reset();
        for (int i = 0; i < LANES; i++) set_lane(0, i, 32767, 32767, 1);
        for (int i = 0; i < LANES; i++) set_lane(1, i, -32768, 32767, 2);
        send_buf(1'b0);
        send_buf(1'b0);
        set_lane(0, 0, 32767, 32767, 1);
        set_lane(0, 1, -32768, 32767, 2);
        set_lane(0, 2, -1, 1, 1);
        send_buf(1'b0);
        do_drain(1'b1);
        do_drain(1'b0);

        // Clear is ignored in S_MAC but honoured in S_IDLE.
        set_lane(exp_side ? 1 : 0, 0, 2, 5, 7);
        set_lane(exp_side ? 1 : 0, 1, 0, 0, 0);
        set_lane(exp_side ? 1 : 0, 2, 0, 0, 0);
        send_buf(1'b1);
        do_drain(1'b0);
        set_lane(exp_side ? 1 : 0, 0, 2, 5, 7);
        set_lane(exp_side ? 1 : 0, 1, 0, 0, 0);
        set_lane(exp_side ? 1 : 0, 2, 0, 0, 0);
        send_buf(1'b0);
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        check("clear_idle_busy", bus.o_busy, 0);
        for (int j = 0; j < PSUM_DEPTH; j++) model[j] = 0;
        do_drain(1'b0);

        // Reset in the middle of S_MAC discards the buffer and zeroes a preloaded array.
        set_lane(exp_side ? 1 : 0, 0, 2, 5, 7);
        send_buf(1'b0);
        set_lane(exp_side ? 1 : 0, 0, 5, 5, 20);
        load_side(exp_side ? 1 : 0);
        if (exp_side) bus.i_left_ready = 1'b1;
        else          bus.i_right_ready = 1'b1;
        @(negedge clk);
        check("mid_taken", bus.o_right_taken | bus.o_left_taken, 1);
        bus.i_right_ready = 1'b0;
        bus.i_left_ready  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset");
        rst = 1'b0;
        exp_side = 1'b0;
        for (int j = 0; j < PSUM_DEPTH; j++) model[j] = 0;
        do_drain(1'b0);

        set_lane(1, 0, 9, 9, 30);
        load_side(1);
        bus.i_left_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("post_reset_left", bus.o_left_taken, 0);
        end
        bus.i_left_ready = 1'b0;
        set_lane(0, 0, 6, 7, 30);
        set_lane(0, 1, 0, 0, 0);
        set_lane(0, 2, 0, 0, 0);
        send_buf(1'b0);
        do_drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_mac_accum.md
Name: pe_mac_accum

Overview:
- Downstream consumer of the sparse VP encoder's ping-pong output buffers (right/left, 3 lanes each).
- Takes one full 3-lane buffer at a time and serialises it, one lane per cycle.
- Each lane computes signed w×ia and accumulates it, with saturation, into an on-chip partial-sum register array indexed by the output-channel field of the lane address.
- Array contents are streamed out with read-and-clear on a drain command.

Parameters:
- LANES, 3, lanes per ping-pong buffer.
- DATA_W, 16, signed w/ia width.
- ACC_W, 32, signed accumulator width.
- COORD_W, 7, width of each of the x, y, k address fields.
- PSUM_DEPTH, 128, accumulator entries; index = k mod PSUM_DEPTH.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_right_ready  in  1  right buffer full/valid (level).
- i_addr_right  in  LANES×3×COORD_W  per-lane address; bits [20:14]=x, [13:7]=y, [6:0]=k.
- i_w_right  in  LANES×DATA_W  signed weights.
- i_ia_right  in  LANES×DATA_W  signed activations.
- i_left_ready / i_addr_left / i_w_left / i_ia_left  in  same widths as the right-side ports  left buffer.
- o_right_taken  out  1  one-cycle pulse: right buffer captured.
- o_left_taken  out  1  one-cycle pulse: left buffer captured.
- o_busy  out  1  high while a buffer or drain is in progress.
- i_clear  in  1  zero the whole array (honoured in S_IDLE only).
- i_drain  in  1  start read-and-clear stream (honoured in S_IDLE only).
- o_psum_valid  out  1  drain data valid.
- i_psum_ready  in  1  drain backpressure.
- o_psum_idx  out  $clog2(PSUM_DEPTH)  drained entry index.
- o_psum_data  out  ACC_W  drained entry value.
- o_done  out  1  one-cycle pulse after the last drained entry is accepted.

Behaviour:
- Reset: state S_IDLE, expected side = RIGHT, lane_cnt 0, all array entries 0. All outputs 0: taken pulses, o_busy, o_psum_valid, o_psum_idx, o_psum_data, o_done.
- Reset mid-operation: the in-flight buffer is discarded and the array is zeroed. No taken or done pulse is issued in the reset cycle.
- States: S_IDLE, S_MAC, S_DRAIN.
- S_IDLE priority: i_clear > accept expected side > i_drain.
  - i_clear: all entries become 0 the next cycle; state stays S_IDLE.
- Accept:
  - Capture happens only from the expected side, when its ready is high; the other side's ready is ignored, including when both are high.
  - On capture at cycle T: the selected buffer is registered, the matching taken signal pulses at T+1, the expected side toggles, state goes to S_MAC, and o_busy is high T+1..T+4.
- S_MAC pipeline:
  - Lane i product (DATA_W×DATA_W → 2·DATA_W signed) is registered at T+1+i.
  - Lane i accumulates at T+2+i: psum[k_i] ← sat(psum[k_i] + sext(prod_i)).
  - Saturation clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - The array is read in the same cycle as it is written, so consecutive lanes hitting the same k see the prior lane's result; no extra hazard logic.
  - Zero-padded lanes (ia=0) add 0 and are not skipped.
  - Returns to S_IDLE after the T+4 accumulate; earliest next capture is T+5.
- S_DRAIN:
  - Entry j is presented with o_psum_valid=1, o_psum_idx=j, o_psum_data=psum[j].
  - On valid&&i_psum_ready the entry is zeroed and j increments.
  - Hold when i_psum_ready=0: data is stable.
  - After j=PSUM_DEPTH−1 is accepted: o_done pulses the next cycle, o_psum_valid falls, state returns to S_IDLE.
- i_clear and i_drain outside S_IDLE are ignored. No buffer is captured during S_MAC or S_DRAIN.

Decomposition:
- Shared package pe_pkg, holding:
  - DATA_W, ACC_W, COORD_W, LANES.
  - typedef pe_addr_t (packed x/y/k struct).
  - typedef lane_t {addr, w, ia}.
  - side enum {SIDE_RIGHT, SIDE_LEFT}.
  - Field-extract function get_k.
- Sub-module sat_add: combinational signed add with saturation, ACC_W parameterised.

Test Plan:
- Reset, then right_ready=1 with lanes (w,ia,k) = (3,4,5), (−2,7,5), (0,0,0) → right_taken pulses once; o_busy high 4 cycles; drain gives psum[5]=−2, all other entries 0, o_done after 128 accepts.
- Left and right ready both high from IDLE → right captured first, then left; taken pulses alternate R, L, R; left_ready alone at start is ignored until a right buffer has been taken.
- Accumulate w=32767, ia=32767 into k=1 repeatedly, three lanes per buffer → value clamps at 2147483647 and never wraps; symmetric test with w=−32768, ia=32767 clamps at −2147483648.
- Drain with i_psum_ready toggling 1,0,0,1 → o_psum_idx/o_psum_data held stable during stalls; a second drain immediately after returns all zeros.
- Assert i_rst at T+2 of S_MAC → next cycle state S_IDLE, all outputs 0; a drain then returns all zeros; expected side is RIGHT.
- i_clear during S_MAC is ignored, while i_clear in S_IDLE zeroes an array preloaded with psum[7]=10 → drain shows psum[7]=0.
